ccd_clock_sequencer: RTL and testbench

Generates the CCD readout clocks: the two-phase horizontal shift clocks `o_phi_l1`/`o_phi_l2` and the transfer pulse `o_phi_p`. All are derived from one system clock by a line-sequencing FSM. This stage sits directly upstream of the analog signal generator, which consumes these three levels to produce pixel flags and ADC frame markers. All outputs are registered, so downstream edge-sensitive logic sees glitch-free levels.

---
 rtl/ccd_clock_sequencer_if.sv | 29 ++
 rtl/ccd_clock_sequencer.sv | 153 +++++++++++++++
 tb/tb_ccd_clock_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ccd_clock_sequencer_if.sv
// ccd_clock_sequencer_if
//   Control/status bundle between a line controller and the CCD clock
//   sequencer.
//   master : drives i_enable / i_start / i_continuous, observes the clocks.
//   slave  : the sequencer; consumes the controls, drives the o_* levels.
//   PIX_W  : width of o_pixel_idx; must match the sequencer's PIX_W.
interface ccd_clock_sequencer_if #(
  parameter int PIX_W = 4
);
  logic             i_enable;
  logic             i_start;
  logic             i_continuous;
  logic             o_phi_l1;
  logic             o_phi_l2;
  logic             o_phi_p;
  logic             o_busy;
  logic             o_line_done;
  logic [PIX_W-1:0] o_pixel_idx;

  modport master (
    output i_enable, i_start, i_continuous,
    input  o_phi_l1, o_phi_l2, o_phi_p, o_busy, o_line_done, o_pixel_idx
  );

  modport slave (
    input  i_enable, i_start, i_continuous,
    output o_phi_l1, o_phi_l2, o_phi_p, o_busy, o_line_done, o_pixel_idx
  );
endinterface

// File: rtl/ccd_clock_sequencer.sv
// ccd_clock_sequencer
//   Line-sequencing FSM producing the CCD readout clocks: transfer pulse
//   phi_p framed by guard intervals, then N_PIXELS two-phase shift periods
//   on phi_l1/phi_l2. Every output comes straight from a flop.
//   i_clk, i_rst_n : system clock, async active-low reset
//   bus (slave)    : i_enable, i_start, i_continuous in;
//                    o_phi_l1, o_phi_l2, o_phi_p, o_busy, o_line_done,
//                    o_pixel_idx out
module ccd_clock_sequencer #(
  parameter int CLK_DIV  = 2,
  parameter int N_PIXELS = 8,
  parameter int T_PULSE  = 4,
  parameter int T_GUARD  = 2,
  parameter int PIX_W    = $clog2(N_PIXELS+1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  ccd_clock_sequencer_if.slave  bus
);

  localparam int CMAX0 = (CLK_DIV > T_PULSE) ? CLK_DIV : T_PULSE;
  localparam int CMAX  = (CMAX0 > T_GUARD) ? CMAX0 : T_GUARD;
  localparam int CW    = $clog2(CMAX+1);
  localparam int HW    = $clog2(2*N_PIXELS+1);

  localparam logic [CW-1:0] DIV_TC  = CW'(CLK_DIV-1);
  localparam logic [CW-1:0] PUL_TC  = CW'(T_PULSE-1);
  localparam logic [CW-1:0] GRD_TC  = CW'(T_GUARD-1);
  localparam logic [HW-1:0] HALF_TC = HW'(2*N_PIXELS-1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_XFER, S_POST, S_SHIFT} state_t;

  state_t           state_q, state_nx;
  logic [CW-1:0]    cnt_q, cnt_nx;     // clocks spent in state / half-period
  logic [HW-1:0]    half_q, half_nx;   // shift half-period index
  logic [PIX_W-1:0] pix_q, pix_nx;
  logic             l1_q, l1_nx, l2_q, l2_nx, p_q, p_nx;
  logic             busy_q, done_q, done_nx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      pix_q   <= '0;
      l1_q    <= 1'b1;
      l2_q    <= 1'b0;
      p_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      half_q  <= half_nx;
      pix_q   <= pix_nx;
      l1_q    <= l1_nx;
      l2_q    <= l2_nx;
      p_q     <= p_nx;
      busy_q  <= (state_nx != S_IDLE);
      done_q  <= done_nx;
    end
  end

  // Output levels are computed for the *next* state so they land in flops
  // on the same edge as the state change.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q + 1'b1;
    half_nx  = half_q;
    pix_nx   = pix_q;
    l1_nx    = 1'b1;
    l2_nx    = 1'b0;
    p_nx     = 1'b0;
    done_nx  = 1'b0;
    if (!bus.i_enable) begin
      // Abort: idle levels, no line_done, pixel index frozen.
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_nx = '0;
          if (bus.i_start) begin
            state_nx = S_PRE;
            pix_nx   = '0;
          end
        end
        S_PRE: begin
          if (cnt_q == GRD_TC) begin
            state_nx = S_XFER;
            cnt_nx   = '0;
            p_nx     = 1'b1;
          end
        end
        S_XFER: begin
          p_nx = 1'b1;
          if (cnt_q == PUL_TC) begin
            state_nx = S_POST;
            cnt_nx   = '0;
            p_nx     = 1'b0;
          end
        end
        S_POST: begin
          if (cnt_q == GRD_TC) begin
            // First shift half-period: phi_l2 rises, pixel 1 begins.
            state_nx = S_SHIFT;
            cnt_nx   = '0;
            half_nx  = '0;
            l1_nx    = 1'b0;
            l2_nx    = 1'b1;
            pix_nx   = pix_q + 1'b1;
          end
        end
        S_SHIFT: begin
          l1_nx = l1_q;
          l2_nx = l2_q;
          if (cnt_q == DIV_TC) begin
            cnt_nx = '0;
            if (half_q == HALF_TC) begin
              // Last half-period was phi_l2 low, so levels are already idle.
              done_nx = 1'b1;
              l1_nx   = 1'b1;
              l2_nx   = 1'b0;
              if (bus.i_continuous) begin
                state_nx = S_PRE;
                pix_nx   = '0;
              end else begin
                state_nx = S_IDLE;
              end
            end else begin
              half_nx = half_q + 1'b1;
              l1_nx   = ~l1_q;
              l2_nx   = ~l2_q;
              if (!l2_q) pix_nx = pix_q + 1'b1;
            end
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign bus.o_phi_l1    = l1_q;
  assign bus.o_phi_l2    = l2_q;
  assign bus.o_phi_p     = p_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_line_done = done_q;
  assign bus.o_pixel_idx = pix_q;

endmodule

// File: tb/tb_ccd_clock_sequencer.sv
// tb_ccd_clock_sequencer
//   Directed bench: default-parameter instance (G=2,P=4,D=2,N=8, L=40) and a
//   minimum-parameter instance (all 1, L=5). Expected levels come from a
//   closed-form timing model of one line, indexed by edges since acceptance.
module tb_ccd_clock_sequencer;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  ccd_clock_sequencer_if #(.PIX_W(4)) bus_a ();
  ccd_clock_sequencer_if #(.PIX_W(1)) bus_b ();

  ccd_clock_sequencer u_dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_a)
  );

  ccd_clock_sequencer #(
    .CLK_DIV (1),
    .N_PIXELS(1),
    .T_PULSE (1),
    .T_GUARD (1)
  ) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Levels after edge t of a line accepted at edge 0.
  task automatic model(input int t, input int g, input int p, input int d, input int n,
                       output int l2, output int ph, output int busy, output int ld,
                       output int idx);
    int len;
    int s;
    len  = 2*g + p + 2*n*d;
    s    = t - (2*g + p);
    l2   = 0;
    ph   = 0;
    ld   = 0;
    idx  = 0;
    busy = (t < len) ? 1 : 0;
    if (t >= len) begin
      ld  = (t == len) ? 1 : 0;
      idx = n;
    end else begin
      ph = (t >= g && t < g + p) ? 1 : 0;
      if (s >= 0) begin
        l2  = ((s / d) % 2 == 0) ? 1 : 0;
        idx = s / (2*d) + 1;
      end
    end
  endtask

  task automatic chk_all(input string nm, input int e,
                         input logic o_l1, input logic o_l2, input logic o_p,
                         input logic o_busy, input logic o_ld, input logic [3:0] o_idx,
                         input int l2, input int ph, input int busy, input int ld,
                         input int idx);
    chk($sformatf("%s.l1@%0d", nm, e),   o_l1,   (l2 == 0) ? 1 : 0);
    chk($sformatf("%s.l2@%0d", nm, e),   o_l2,   l2);
    chk($sformatf("%s.p@%0d", nm, e),    o_p,    ph);
    chk($sformatf("%s.busy@%0d", nm, e), o_busy, busy);
    chk($sformatf("%s.done@%0d", nm, e), o_ld,   ld);
    chk($sformatf("%s.idx@%0d", nm, e),  o_idx,  idx);
  endtask

  task automatic chk_a(input string nm, input int e, input int l2, input int ph,
                       input int busy, input int ld, input int idx);
    chk_all(nm, e, bus_a.o_phi_l1, bus_a.o_phi_l2, bus_a.o_phi_p, bus_a.o_busy,
            bus_a.o_line_done, 4'(bus_a.o_pixel_idx), l2, ph, busy, ld, idx);
  endtask

  // One default line accepted at edge 0; optional start pulses sampled in
  // non-IDLE states, optional enable drop after edge abort_at.
  task automatic run_a(input string nm, input int pulse1, input int pulse2, input int abort_at);
    int l2, ph, busy, ld, idx, hold_idx;
    hold_idx = 0;
    bus_a.i_enable     = 1'b1;
    bus_a.i_continuous = 1'b0;
    bus_a.i_start      = 1'b1;
    for (int e = 0; e <= 45; e++) begin
      step();
      bus_a.i_start = (e == pulse1 || e == pulse2);
      if (e == abort_at) bus_a.i_enable = 1'b0;
      model(e, 2, 4, 2, 8, l2, ph, busy, ld, idx);
      if (abort_at >= 0 && e > abort_at) begin
        l2 = 0; ph = 0; busy = 0; ld = 0; idx = hold_idx;
      end else begin
        hold_idx = idx;
      end
      chk_a(nm, e, l2, ph, busy, ld, idx);
    end
    bus_a.i_start = 1'b0;
  endtask

  initial begin
    int l2, ph, busy, ld, idx, n_done;
    rst_n = 1'b0;
    bus_a.i_enable = 1'b0; bus_a.i_start = 1'b0; bus_a.i_continuous = 1'b0;
    bus_b.i_enable = 1'b0; bus_b.i_start = 1'b0; bus_b.i_continuous = 1'b0;

    // Reset state, with a clock edge seen during reset.
    #12;
    chk_a("rst", -1, 0, 0, 0, 0, 0);
    chk_all("rstb", -1, bus_b.o_phi_l1, bus_b.o_phi_l2, bus_b.o_phi_p, bus_b.o_busy,
            bus_b.o_line_done, 4'(bus_b.o_pixel_idx), 0, 0, 0, 0, 0);
    #8 rst_n = 1'b1;
    step();

    // Single line with default parameters.
    run_a("line", -1, -1, -1);

    // Start pulses in PRE (sampled at edge 2) and SHIFT (edge 16) ignored.
    run_a("nstart", 1, 15, -1);
    for (int e = 46; e < 56; e++) begin
      step();
      chk($sformatf("nstart.busy@%0d", e), bus_a.o_busy, 0);
      chk($sformatf("nstart.done@%0d", e), bus_a.o_line_done, 0);
    end

    // Abort mid-SHIFT, then a fresh line restarting pixel_idx from 0.
    run_a("abort", -1, -1, 20);
    run_a("reline", -1, -1, -1);

    // Continuous mode, three back-to-back lines.
    n_done = 0;
    bus_a.i_enable = 1'b1; bus_a.i_continuous = 1'b1; bus_a.i_start = 1'b1;
    for (int e = 0; e <= 124; e++) begin
      step();
      bus_a.i_start = 1'b0;
      if (e == 80) bus_a.i_continuous = 1'b0;
      if (e < 120) begin
        model(e % 40, 2, 4, 2, 8, l2, ph, busy, ld, idx);
        if (e % 40 == 0 && e > 0) ld = 1;
      end else begin
        model(e - 80, 2, 4, 2, 8, l2, ph, busy, ld, idx);
      end
      n_done += int'(bus_a.o_line_done);
      chk_a("cont", e, l2, ph, busy, ld, idx);
    end
    chk("cont.ndone", n_done, 3);

    // Asynchronous reset in the middle of XFER.
    bus_a.i_start = 1'b1;
    step();
    bus_a.i_start = 1'b0;
    repeat (3) step();
    chk("arst.p_before", bus_a.o_phi_p, 1);
    #3 rst_n = 1'b0;
    #1;
    chk_a("arst", 0, 0, 0, 0, 0, 0);
    bus_a.i_start = 1'b1;
    repeat (3) step();
    chk_a("arst_hold", 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.i_start = 1'b0;
    step();
    chk_a("arst_rel", 4, 0, 0, 0, 0, 0);
    bus_a.i_enable = 1'b0;

    // Minimum parameters: L = 5.
    bus_b.i_enable = 1'b1; bus_b.i_start = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      step();
      bus_b.i_start = 1'b0;
      model(e, 1, 1, 1, 1, l2, ph, busy, ld, idx);
      chk_all("min", e, bus_b.o_phi_l1, bus_b.o_phi_l2, bus_b.o_phi_p, bus_b.o_busy,
              bus_b.o_line_done, 4'(bus_b.o_pixel_idx), l2, ph, busy, ld, idx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
